// File: rtl/inst_text_writer_pkg.sv
// rtl/inst_text_writer_pkg.sv - shared constants, state type and byte sanitiser for the text writer
package inst_text_writer_pkg;

    localparam int STR_LEN = 19;
    localparam int CHAR_W  = 8;
    localparam logic [CHAR_W-1:0] CHAR_REPL = 8'h3F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FIN   = 2'd2
    } state_t;

    // Non-printable bytes become '?' so the display never shows control codes
    function automatic logic [CHAR_W-1:0] sanitize_char(input logic [CHAR_W-1:0] c);
        return ((c >= 8'h20) && (c <= 8'h7E)) ? c : CHAR_REPL;
    endfunction

endpackage

// File: rtl/inst_text_writer_if.sv
// rtl/inst_text_writer_if.sv - request and character RAM write bundle for the text writer
interface inst_text_writer_if #(
    parameter int ADDR_W = 12
);
    import inst_text_writer_pkg::*;

    logic [STR_LEN*CHAR_W-1:0] inst;
    logic [4:0]                row;
    logic [6:0]                col;
    logic                      req_valid;
    logic                      req_ready;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [CHAR_W-1:0]         wr_data;
    logic                      done;

    modport master (
        output inst, row, col, req_valid,
        input  req_ready, wr_en, wr_addr, wr_data, done
    );

    modport slave (
        input  inst, row, col, req_valid,
        output req_ready, wr_en, wr_addr, wr_data, done
    );

endinterface

// File: rtl/inst_text_writer_addr_gen.sv
// rtl/inst_text_writer_addr_gen.sv - text_addr_gen: combinational row/col/idx to RAM address
module text_addr_gen #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic [4:0]        i_row,
    input  logic [6:0]        i_col,
    input  logic [4:0]        i_idx,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_in_range
);

    logic [7:0] w_col_sum;

    // Column sum is 8 bits wide so col+idx past the row edge is detected rather than wrapped
    always_comb begin
        w_col_sum  = {1'b0, i_col} + {3'b000, i_idx};
        o_addr     = ADDR_W'(i_row) * ADDR_W'(COLS) + ADDR_W'(w_col_sum);
        o_in_range = (w_col_sum < 8'(COLS)) && (i_row < 5'(ROWS));
    end

endmodule

// File: rtl/inst_text_writer.sv
// rtl/inst_text_writer.sv - streams a 19-char mnemonic into the VGA character RAM; optional INST_TEXT_SKIP_EN
module inst_text_writer
    import inst_text_writer_pkg::*;
#(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic               i_clk,
    input  logic               i_rst,
    inst_text_writer_if.slave  bus
);

    state_t                    r_state;
    logic [STR_LEN*CHAR_W-1:0] r_inst;
    logic [4:0]                r_row;
    logic [6:0]                r_col;
    logic [4:0]                r_idx;
    logic                      r_req_ready;
    logic                      r_wr_en;
    logic [ADDR_W-1:0]         r_wr_addr;
    logic [CHAR_W-1:0]         r_wr_data;
    logic                      r_done;

    logic                      w_accept;
    logic                      w_skip;
    logic [STR_LEN*CHAR_W-1:0] w_inst;
    logic [STR_LEN*CHAR_W-1:0] w_word;
    logic [4:0]                w_row;
    logic [6:0]                w_col;
    logic [4:0]                w_idx;
    logic [4:0]                w_pos;
    logic [7:0]                w_shift;
    logic [CHAR_W-1:0]         w_char;
    logic [ADDR_W-1:0]         w_addr;
    logic                      w_in_range;

    assign w_accept = bus.req_valid && r_req_ready;

    // Outputs are registered one character ahead: on accept the first character comes
    // straight from the request inputs, afterwards from the latched copy at idx+1
    always_comb begin
        w_inst  = w_accept ? bus.inst : r_inst;
        w_row   = w_accept ? bus.row  : r_row;
        w_col   = w_accept ? bus.col  : r_col;
        w_idx   = w_accept ? 5'd0     : r_idx + 5'd1;
        w_pos   = 5'(STR_LEN - 1) - w_idx;
        w_shift = {w_pos, 3'b000};
        w_word  = w_inst >> w_shift;
        w_char  = sanitize_char(w_word[CHAR_W-1:0]);
    end

    text_addr_gen #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .i_row      (w_row),
        .i_col      (w_col),
        .i_idx      (w_idx),
        .o_addr     (w_addr),
        .o_in_range (w_in_range)
    );

`ifdef INST_TEXT_SKIP_EN
    logic                      r_c_valid;
    logic [STR_LEN*CHAR_W-1:0] r_c_inst;
    logic [4:0]                r_c_row;
    logic [6:0]                r_c_col;

    assign w_skip = r_c_valid && (r_c_inst == bus.inst) &&
                    (r_c_row == bus.row) && (r_c_col == bus.col);

    // Remember the last accepted request; reset only invalidates it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_c_valid <= 1'b0;
        end else if (w_accept) begin
            r_c_valid <= 1'b1;
            r_c_inst  <= bus.inst;
            r_c_row   <= bus.row;
            r_c_col   <= bus.col;
        end
    end
`else
    assign w_skip = 1'b0;
`endif

    // Control FSM with registered handshake and RAM write outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_idx       <= 5'd0;
            r_req_ready <= 1'b1;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_inst      <= bus.inst;
                        r_row       <= bus.row;
                        r_col       <= bus.col;
                        r_idx       <= 5'd0;
                        r_req_ready <= 1'b0;
                        if ((bus.row >= 5'(ROWS)) || w_skip) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= WRITE;
                            r_wr_en <= w_in_range;
                            if (w_in_range) begin
                                r_wr_addr <= w_addr;
                                r_wr_data <= w_char;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (r_idx == 5'(STR_LEN - 1)) begin
                        r_wr_en <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= FIN;
                    end else begin
                        r_idx   <= r_idx + 5'd1;
                        r_wr_en <= w_in_range;
                        if (w_in_range) begin
                            r_wr_addr <= w_addr;
                            r_wr_data <= w_char;
                        end
                    end
                end
                FIN: begin
                    r_done      <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_wr_en     <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_inst_text_writer.sv
// tb/tb_inst_text_writer.sv - randomized self-checking bench with a request-level reference model
module tb_inst_text_writer;

    localparam int COLS = 80;
    localparam int ROWS = 30;
`ifdef INST_TEXT_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    // model state: last accepted request and the held RAM write bus values
    bit           m_c_valid = 1'b0;
    logic [151:0] m_c_inst;
    int           m_c_row;
    int           m_c_col;
    int           m_addr = 0;
    int           m_data = 0;

    // per-request observations for directed checks
    int           o_writes;
    int           o_first_addr;
    int           o_first_data;
    int           o_last_addr;
    int           o_last_data;
    int           o_done_k;

    inst_text_writer_if #(.ADDR_W(12)) bus ();

    inst_text_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(12)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_char(input logic [151:0] s, input int i);
        logic [7:0] c;
        c = s[151 - 8*i -: 8];
        if (c < 8'h20 || c > 8'h7E) return 32'h3F;
        return int'(c);
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 0, 1);
    endtask

    task automatic run_req(input logic [151:0] s, input int row, input int col);
        bit ok;
        bit skip;
        bit oob;
        int done_k;
        bit exp_en;
        wait_ready(ok);
        o_writes = 0; o_done_k = -1;
        o_first_addr = -1; o_first_data = -1; o_last_addr = -1; o_last_data = -1;
        if (!ok) return;
        skip = SKIP_EN && m_c_valid && (m_c_inst == s) && (m_c_row == row) && (m_c_col == col);
        oob  = (row >= ROWS);
        done_k = (skip || oob) ? 1 : 20;
        bus.inst = s; bus.row = 5'(row); bus.col = 7'(col); bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.inst = {$urandom, $urandom, $urandom, $urandom, $urandom};
        bus.row = 5'($urandom); bus.col = 7'($urandom);
        for (int k = 1; k <= done_k + 1; k++) begin
            @(negedge clk);
            exp_en = !skip && !oob && (k <= 19) && (col + k - 1 < COLS);
            if (exp_en) begin
                m_addr = row * COLS + col + k - 1;
                m_data = model_char(s, k - 1);
            end
            check("wr_en", bus.wr_en, exp_en);
            check("wr_addr", bus.wr_addr, m_addr);
            check("wr_data", bus.wr_data, m_data);
            check("done", bus.done, (k == done_k));
            check("req_ready", bus.req_ready, (k == done_k + 1));
            if (bus.wr_en === 1'b1) begin
                if (o_writes == 0) begin
                    o_first_addr = int'(bus.wr_addr);
                    o_first_data = int'(bus.wr_data);
                end
                o_last_addr = int'(bus.wr_addr);
                o_last_data = int'(bus.wr_data);
                o_writes++;
            end
            if (bus.done === 1'b1) o_done_k = k;
        end
        m_c_valid = 1'b1; m_c_inst = s; m_c_row = row; m_c_col = col;
    endtask

    task automatic run_reset_abort();
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        bus.inst = "reset abort testing"; bus.row = 5'd3; bus.col = 7'd5; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("abort_wr_en", bus.wr_en, 1);
        end
        rst = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            check("abort_rst_wr_en", bus.wr_en, 0);
            check("abort_rst_done", bus.done, 0);
        end
        rst = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (j == 0) check("abort_ready", bus.req_ready, 1);
            check("abort_post_wr_en", bus.wr_en, 0);
            check("abort_post_done", bus.done, 0);
        end
        check("abort_addr", bus.wr_addr, 0);
        m_c_valid = 1'b0; m_addr = 0; m_data = 0;
    endtask

    initial begin
        logic [151:0] s;
        bus.req_valid = 1'b0; bus.inst = '0; bus.row = '0; bus.col = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", bus.req_ready, 1);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_done", bus.done, 0);

        s = "nop SBubble:addi 00";
        run_req(s, 2, 10);
        check("t1_writes", o_writes, 19);
        check("t1_first_addr", o_first_addr, 170);
        check("t1_first_data", o_first_data, 32'h6E);
        check("t1_last_addr", o_last_addr, 188);
        check("t1_last_data", o_last_data, 32'h30);
        check("t1_done_k", o_done_k, 20);

        run_req(s, 0, 70);
        check("t2_writes", o_writes, 10);
        check("t2_last_addr", o_last_addr, 79);
        check("t2_done_k", o_done_k, 20);

        run_req(s, 30, 4);
        check("t3_writes", o_writes, 0);
        check("t3_done_k", o_done_k, 1);

        s = "add x1, x2, x3     ";
        s[151 - 8*5 -: 8] = 8'h00;
        run_req(s, 7, 0);
        check("t4_writes", o_writes, 19);

        run_reset_abort();

        s = "lw x5, 8(x2)       ";
        run_req(s, 12, 40);
        check("t6_first_writes", o_writes, 19);
        run_req(s, 12, 40);
        check("t6_repeat_writes", o_writes, SKIP_EN ? 0 : 19);
        check("t6_repeat_done_k", o_done_k, SKIP_EN ? 1 : 20);
        s[151 -: 8] = "s";
        run_req(s, 12, 40);
        check("t6_changed_writes", o_writes, 19);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 19; i++) begin
                if ($urandom_range(0, 3) == 0) s[151 - 8*i -: 8] = 8'($urandom);
                else s[151 - 8*i -: 8] = 8'($urandom_range(32'h20, 32'h7E));
            end
            run_req(s, int'($urandom_range(0, 31)), int'($urandom_range(0, 127)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
